// File: rtl/exe_muldiv_ctrl.sv
// Iterative radix-2 multiply/divide sequencer owning HI/LO, with MTHI/MTLO and pipeline stall.
// Optional MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle multiplier and skip CALC.
module exe_muldiv_ctrl #(
  parameter int unsigned ITER    = 32,
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  input  logic        cancel,
  input  logic        mf_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_e;

  localparam int unsigned CNT_W   = $clog2(ITER + 1);
  localparam logic [2:0]  OP_MULT = 3'd1;
  localparam logic [2:0]  OP_DIV  = 3'd3;
  localparam logic [2:0]  OP_DIVU = 3'd4;
  localparam logic [2:0]  OP_MTHI = 3'd5;
  localparam logic [2:0]  OP_MTLO = 3'd6;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        acc_q, acc_d;
  logic [31:0]        opb_q, opb_d;
  logic [31:0]        rs_q, rs_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d, div0_q, div0_d;
  logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic               done_q, done_d;

  logic               op_valid, accept, sgn_req, div_req;
  logic [31:0]        mag_rs, mag_rt;
  logic [32:0]        mul_sum, div_rem_sh;
  logic [31:0]        div_diff;
  logic               div_ge;
  logic [63:0]        prod_fix;
  logic [31:0]        quo_fix, rem_fix;

  // Handshake: a request transfers on a rising edge where req_valid & req_ready and the op
  // is 1..6; NOP/reserved ops never transfer and never stall.
  assign op_valid  = (req_op != 3'd0) && (req_op != 3'd7);
  assign req_ready = (state_q == S_IDLE) & ~cancel;
  assign accept    = req_valid & req_ready & op_valid;
  assign sgn_req   = (req_op == OP_MULT) | (req_op == OP_DIV);
  assign div_req   = (req_op == OP_DIV) | (req_op == OP_DIVU);
  assign mag_rs    = (sgn_req & req_rs[31]) ? -req_rs : req_rs;
  assign mag_rt    = (sgn_req & req_rt[31]) ? -req_rt : req_rt;

  // acc holds {partial, multiplier} for mul and {remainder, quotient} for div.
  assign mul_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign div_rem_sh = acc_q[63:31];
  assign div_ge     = div_rem_sh >= {1'b0, opb_q};
  assign div_diff   = div_rem_sh[31:0] - opb_q;

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[31:0] : acc_q[31:0];
  assign rem_fix  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];

`ifdef MULDIV_FAST_MUL_EN
  logic signed [65:0] fast_a, fast_b, fast_p;
  assign fast_a = $signed({{34{sgn_req & req_rs[31]}}, req_rs});
  assign fast_b = $signed({{34{sgn_req & req_rt[31]}}, req_rt});
  assign fast_p = fast_a * fast_b;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    rs_d      = rs_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_op == OP_MTHI) begin
            hi_d = req_rs;
          end else if (req_op == OP_MTLO) begin
            lo_d = req_rs;
          end else begin
            is_div_d  = div_req;
            div0_d    = div_req & (req_rt == 32'd0);
            neg_res_d = sgn_req & (req_rs[31] ^ req_rt[31]);
            neg_rem_d = sgn_req & req_rs[31];
            rs_d      = req_rs;
            opb_d     = div_req ? mag_rt : mag_rs;
            acc_d     = {32'd0, div_req ? mag_rs : mag_rt};
            cnt_d     = '0;
            state_d   = S_CALC;
`ifdef MULDIV_FAST_MUL_EN
            if (!div_req) begin
              acc_d     = fast_p[63:0];
              neg_res_d = 1'b0;
              state_d   = S_FIN;
            end
`endif
          end
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) acc_d = {div_ge ? div_diff : div_rem_sh[31:0], acc_q[30:0], div_ge};
          else          acc_d = {mul_sum, acc_q[31:1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q && div0_q) begin
            hi_d = rs_q;
            lo_d = DIV0_LO;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      rs_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      rs_q      <= rs_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign stall = busy & ((req_valid & op_valid) | mf_req);
endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Directed self-checking bench for exe_muldiv_ctrl (HI/LO results, latency, stall, cancel, reset).
module tb_exe_muldiv_ctrl;
  logic        clk, rst_n, req_valid, req_ready, cancel, mf_req;
  logic [2:0]  req_op;
  logic [31:0] req_rs, req_rt, hi, lo;
  logic        busy, stall, done;
  int          n_cmp, n_err;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  exe_muldiv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .cancel(cancel),
    .mf_req(mf_req), .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change only between edges
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    req_op = op; req_rs = rs; req_rt = rt; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'd0;
    req_rs = $urandom; req_rt = $urandom;
  endtask

  // counts busy cycles at negedges; stops on the first idle negedge or after 200 cycles
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_rs = '0; req_rt = '0;
    cancel = 1'b0; mf_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
    n_cmp++; if ({busy, done, stall} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy, done, stall}); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_mult;
    int n;
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    n_cmp++; if (n !== MUL_LAT) begin n_err++; $display("FAIL mult_latency: got %0d want %0d", n, MUL_LAT); end
    n_cmp++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_err++; $display("FAIL mult_result: got %h want FFFFFFFFFFFFFFFA", {hi, lo}); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL mult_done: got %b want 1", done); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mult_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_multu;
    int n;
    issue(3'd2, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    n_cmp++; if (n !== MUL_LAT) begin n_err++; $display("FAIL multu_latency: got %0d want %0d", n, MUL_LAT); end
    n_cmp++; if ({hi, lo} !== 64'h0000_0002_FFFF_FFFA) begin n_err++; $display("FAIL multu_result: got %h want 00000002FFFFFFFA", {hi, lo}); end
  endtask

  task automatic test_div;
    int n;
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    n_cmp++; if (n !== 33) begin n_err++; $display("FAIL div_latency: got %0d want 33", n); end
    n_cmp++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL div_neg7_2: got %h want FFFFFFFFFFFFFFFD", {hi, lo}); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL div_done: got %b want 1", done); end
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    n_cmp++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin n_err++; $display("FAIL div_overflow: got %h want 0000000080000000", {hi, lo}); end
    issue(3'd4, 32'd100, 32'd7);
    wait_idle(n);
    n_cmp++; if ({hi, lo} !== 64'h0000_0002_0000_000E) begin n_err++; $display("FAIL divu_100_7: got %h want 000000020000000E", {hi, lo}); end
    issue(3'd3, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    n_cmp++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin n_err++; $display("FAIL div_7_neg2: got %h want 00000001FFFFFFFD", {hi, lo}); end
  endtask

  task automatic test_div0;
    int n;
    issue(3'd4, 32'd7, 32'd0);
    wait_idle(n);
    n_cmp++; if (n !== 33) begin n_err++; $display("FAIL divu0_latency: got %0d want 33", n); end
    n_cmp++; if ({hi, lo} !== 64'h0000_0007_FFFF_FFFF) begin n_err++; $display("FAIL divu0_result: got %h want 00000007FFFFFFFF", {hi, lo}); end
    issue(3'd3, 32'hFFFF_FFFB, 32'd0);
    wait_idle(n);
    n_cmp++; if ({hi, lo} !== 64'hFFFF_FFFB_FFFF_FFFF) begin n_err++; $display("FAIL div0_signed: got %h want FFFFFFFBFFFFFFFF", {hi, lo}); end
  endtask

  task automatic test_mthi_mtlo;
    issue(3'd5, 32'h1234_5678, 32'd0);
    @(negedge clk);
    n_cmp++; if ({hi, lo} !== 64'h1234_5678_FFFF_FFFF) begin n_err++; $display("FAIL mthi: got %h want 12345678FFFFFFFF", {hi, lo}); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL mthi_flags: got %b want 00", {busy, done}); end
    issue(3'd6, 32'hA5A5_0F0F, 32'd0);
    @(negedge clk);
    n_cmp++; if ({hi, lo} !== 64'h1234_5678_A5A5_0F0F) begin n_err++; $display("FAIL mtlo: got %h want 12345678A5A50F0F", {hi, lo}); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL mtlo_flags: got %b want 00", {busy, done}); end
  endtask

  task automatic test_back_to_back;
    int n, bad;
    issue(3'd4, 32'd100, 32'd7);
    req_valid = 1'b1; req_op = 3'd6; req_rs = 32'hCAFE_F00D;
    n = 0; bad = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      if (stall !== 1'b1 || req_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    n_cmp++; if (n !== 33) begin n_err++; $display("FAIL b2b_busy: got %0d want 33", n); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL b2b_stall_cycles: got %0d bad want 0", bad); end
    n_cmp++; if ({stall, req_ready} !== 2'b01) begin n_err++; $display("FAIL b2b_idle_ready: got %b want 01", {stall, req_ready}); end
    n_cmp++; if ({hi, lo} !== 64'h0000_0002_0000_000E) begin n_err++; $display("FAIL b2b_div_result: got %h want 000000020000000E", {hi, lo}); end
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'd0;
    @(negedge clk);
    n_cmp++; if ({hi, lo} !== 64'h0000_0002_CAFE_F00D) begin n_err++; $display("FAIL b2b_mtlo: got %h want 00000002CAFEF00D", {hi, lo}); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL b2b_mtlo_flags: got %b want 00", {busy, done}); end
  endtask

  task automatic test_mf_stall;
    int n, bad;
    issue(3'd3, 32'd7, 32'hFFFF_FFFE);
    mf_req = 1'b1;
    n = 0; bad = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      if (stall !== 1'b1) bad++;
      @(negedge clk);
    end
    n_cmp++; if (n !== 33 || bad !== 0) begin n_err++; $display("FAIL mf_stall_cycles: got %0d busy %0d unstalled want 33 0", n, bad); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mf_stall_idle: got %b want 0", stall); end
    n_cmp++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin n_err++; $display("FAIL mf_hilo: got %h want 00000001FFFFFFFD", {hi, lo}); end
    mf_req = 1'b0;
  endtask

  task automatic test_cancel_calc;
    int dn;
    issue(3'd4, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    cancel = 1'b1;
    #1;
    n_cmp++; if ({busy, req_ready} !== 2'b10) begin n_err++; $display("FAIL cancel_calc_pre: got %b want 10", {busy, req_ready}); end
    @(posedge clk); #1 cancel = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cancel_calc_idle: got %b want 0", busy); end
    dn = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) dn++; end
    n_cmp++; if (dn !== 0) begin n_err++; $display("FAIL cancel_calc_done: got %0d pulses want 0", dn); end
    n_cmp++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin n_err++; $display("FAIL cancel_calc_hilo: got %h want 00000001FFFFFFFD", {hi, lo}); end
  endtask

  task automatic test_cancel_fin;
    issue(3'd4, 32'd100, 32'd7);
    repeat (32) begin @(posedge clk); #1; end
    cancel = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL cancel_fin_pre: got %b want 1", busy); end
    @(posedge clk); #1 cancel = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL cancel_fin_flags: got %b want 00", {busy, done}); end
    n_cmp++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin n_err++; $display("FAIL cancel_fin_hilo: got %h want 00000001FFFFFFFD", {hi, lo}); end
  endtask

  task automatic test_nop;
    int n;
    req_valid = 1'b1; req_op = 3'd0;
    @(posedge clk); #1 req_op = 3'd7;
    @(posedge clk); #1 req_valid = 1'b0; req_op = 3'd0;
    @(negedge clk);
    n_cmp++; if ({busy, done, hi, lo} !== {2'b00, 64'h0000_0001_FFFF_FFFD}) begin n_err++; $display("FAIL nop_idle: got %h want 0_00000001FFFFFFFD", {busy, done, hi, lo}); end
    issue(3'd4, 32'd9, 32'd4);
    req_valid = 1'b1; req_op = 3'd7;
    #1;
    n_cmp++; if ({busy, stall} !== 2'b10) begin n_err++; $display("FAIL nop_rsvd_stall: got %b want 10", {busy, stall}); end
    req_op = 3'd0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL nop_op0_stall: got %b want 0", stall); end
    req_op = 3'd5;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL nop_mthi_stall: got %b want 1", stall); end
    req_valid = 1'b0; req_op = 3'd0;
    wait_idle(n);
    n_cmp++; if ({hi, lo} !== 64'h0000_0001_0000_0002) begin n_err++; $display("FAIL nop_divu_9_4: got %h want 0000000100000002", {hi, lo}); end
  endtask

  task automatic test_reset_mid;
    issue(3'd3, 32'd1000, 32'd3);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, hi, lo} !== 66'd0) begin n_err++; $display("FAIL reset_mid: got %h want 0", {busy, done, hi, lo}); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fast_mul;
    int n;
    issue(3'd1, 32'h0001_0000, 32'h0001_0000);
    wait_idle(n);
    n_cmp++; if (n !== MUL_LAT) begin n_err++; $display("FAIL fastmul_latency: got %0d want %0d", n, MUL_LAT); end
    n_cmp++; if ({hi, lo} !== 64'h0000_0001_0000_0000) begin n_err++; $display("FAIL fastmul_result: got %h want 0000000100000000", {hi, lo}); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL fastmul_done: got %b want 1", done); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_div0;
    test_mthi_mtlo;
    test_back_to_back;
    test_mf_stall;
    test_cancel_calc;
    test_cancel_fin;
    test_nop;
    test_reset_mid;
    test_fast_mul;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
